// File: rtl/uart_rx_tx_fifo.sv
// Purpose : byte FIFO between a UART receiver and a UART transmitter, with a launch FSM that
//           feeds the transmitter one byte at a time.
// Latency : a push into an empty FIFO with the transmitter idle gives o_Tx_DV one cycle later.
// Backpressure: launches wait for i_Tx_Active=0 and i_Tx_Done; pushes into a full FIFO with no
//           same-edge pop are dropped and set the sticky o_Overflow flag.
//
// Ports:
//   i_Clock, i_Rst_n         clock and synchronous active-low reset
//   i_Rx_DV, i_Rx_Byte       receive strobe and byte (push side)
//   i_Tx_Active, i_Tx_Done   transmitter busy level and completion strobe
//   i_Clr_Ovf                clears o_Overflow (a same-edge drop wins)
//   o_Tx_DV, o_Tx_Byte       one-cycle launch strobe and byte to transmit
//   o_Count, o_Empty, o_Full occupancy 0..DEPTH and its derived flags
//   o_Overflow               sticky: a received byte was dropped
module uart_rx_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Empty,
  output logic              o_Full,
  output logic              o_Overflow
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic                pop;
  logic                push;
  logic                drop;

  assign o_Count = count;
  assign o_Empty = (count == '0);
  assign o_Full  = (count == (ADDR_W+1)'(DEPTH));

  // The FSM pops the head on the same edge it registers the launch strobe.
  assign pop  = (state == IDLE) && !o_Empty && !i_Tx_Active;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push = i_Rx_DV && (!o_Full || pop);
  assign drop = i_Rx_DV && o_Full && !pop;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (i_Rst_n && push) begin
      mem[wr_ptr] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // A drop on the clear edge wins so the loss is never hidden.
      if (drop)           o_Overflow <= 1'b1;
      else if (i_Clr_Ovf) o_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= mem[rd_ptr];
            state     <= LAUNCH;
          end
        end
        // One cycle for the transmitter to raise i_Tx_Active before we
        // start listening for its done strobe.
        LAUNCH:    state <= WAIT_DONE;
        WAIT_DONE: if (i_Tx_Done) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
module tb_uart_rx_tx_fifo;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       i_Clr_Ovf;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic [4:0] o_Count;
  logic       o_Empty;
  logic       o_Full;
  logic       o_Overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];

  uart_rx_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .i_Clr_Ovf   (i_Clr_Ovf),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Count     (o_Count),
    .o_Empty     (o_Empty),
    .o_Full      (o_Full),
    .o_Overflow  (o_Overflow)
  );

  always #5 i_Clock = ~i_Clock;

  // Every cycle with o_Tx_DV high records one launched byte.
  always @(negedge i_Clock) begin
    if (o_Tx_DV === 1'b1) tx_q.push_back(o_Tx_Byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV   = 1'b0;
  endtask

  // Waits for each launch, then answers with i_Tx_Done 10 cycles later.
  task automatic drain(input int n);
    for (int j = 0; j < n; j++) begin
      int w = 0;
      while (o_Tx_DV !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      if (o_Tx_DV !== 1'b1) check("launch_timeout", 32'(o_Tx_DV), 32'd1);
      for (int k = 0; k < 10; k++) tick();
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    i_Rst_n = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
    i_Tx_Active = 1'b0; i_Tx_Done = 1'b0; i_Clr_Ovf = 1'b0;
    tick(); tick();
    check("rst_count", 32'(o_Count), 32'd0);
    check("rst_empty", 32'(o_Empty), 32'd1);
    check("rst_full",  32'(o_Full), 32'd0);
    check("rst_ovf",   32'(o_Overflow), 32'd0);
    check("rst_txdv",  32'(o_Tx_DV), 32'd0);
    check("rst_txbyte", 32'(o_Tx_Byte), 32'h00);
    i_Rst_n = 1'b1;
    tick();

    // Single byte: strobe appears in the cycle after the edge following the push.
    push_byte(8'hA5);
    check("single_count_after_push", 32'(o_Count), 32'd1);
    check("single_txdv_early", 32'(o_Tx_DV), 32'd0);
    tick();
    check("single_txdv", 32'(o_Tx_DV), 32'd1);
    check("single_txbyte", 32'(o_Tx_Byte), 32'hA5);
    check("single_count_zero", 32'(o_Count), 32'd0);
    tick();
    check("single_txdv_one_cycle", 32'(o_Tx_DV), 32'd0);
    check("single_txbyte_hold", 32'(o_Tx_Byte), 32'hA5);
    i_Tx_Done = 1'b1; tick(); i_Tx_Done = 1'b0;
    tick(); tick();
    check("single_no_relaunch", 32'(o_Tx_DV), 32'd0);

    // Fill while the transmitter is busy, then overflow.
    i_Tx_Active = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", 32'(o_Full), 32'd1);
    check("fill_count", 32'(o_Count), 32'd16);
    check("fill_ovf_clear", 32'(o_Overflow), 32'd0);
    push_byte(8'hFF);
    check("ovf_set", 32'(o_Overflow), 32'd1);
    check("ovf_count", 32'(o_Count), 32'd16);

    // Clear racing a drop: the drop wins; a later lone clear works.
    i_Clr_Ovf = 1'b1;
    push_byte(8'hEE);
    check("ovf_race", 32'(o_Overflow), 32'd1);
    tick();
    i_Clr_Ovf = 1'b0;
    check("ovf_cleared", 32'(o_Overflow), 32'd0);
    check("ovf_count_kept", 32'(o_Count), 32'd16);

    // Drain in order; dropped bytes never appear.
    base = tx_q.size();
    i_Tx_Active = 1'b0;
    drain(16);
    tick(); tick(); tick();
    check("drain_n", 32'(tx_q.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      if (base + i < tx_q.size()) check("drain_byte", 32'(tx_q[base+i]), 32'(i));
    check("drain_empty", 32'(o_Empty), 32'd1);
    check("drain_count", 32'(o_Count), 32'd0);

    // Push and pop on the same edge while full.
    i_Tx_Active = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    check("pp_full", 32'(o_Full), 32'd1);
    base = tx_q.size();
    i_Tx_Active = 1'b0;
    push_byte(8'h55);
    check("pp_count", 32'(o_Count), 32'd16);
    check("pp_ovf", 32'(o_Overflow), 32'd0);
    check("pp_txdv", 32'(o_Tx_DV), 32'd1);
    check("pp_txbyte", 32'(o_Tx_Byte), 32'h10);
    drain(17);
    tick(); tick();
    check("pp_n", 32'(tx_q.size() - base), 32'd17);
    for (int i = 0; i < 16; i++)
      if (base + i < tx_q.size()) check("pp_byte", 32'(tx_q[base+i]), 32'(8'h10 + i));
    if (base + 16 < tx_q.size()) check("pp_last", 32'(tx_q[base+16]), 32'h55);
    check("pp_empty", 32'(o_Empty), 32'd1);

    // Reset while five bytes wait and the FSM is in WAIT_DONE.
    for (int i = 0; i < 6; i++) push_byte(8'(8'h30 + i));
    check("mid_count", 32'(o_Count), 32'd5);
    tick();
    i_Rst_n = 1'b0;
    tick();
    i_Rst_n = 1'b1;
    base = tx_q.size();
    check("mid_rst_count", 32'(o_Count), 32'd0);
    check("mid_rst_txdv", 32'(o_Tx_DV), 32'd0);
    check("mid_rst_empty", 32'(o_Empty), 32'd1);
    check("mid_rst_txbyte", 32'(o_Tx_Byte), 32'h00);
    i_Tx_Done = 1'b1; tick(); i_Tx_Done = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("mid_no_launch", 32'(tx_q.size() - base), 32'd0);

    // A stray done while IDLE must not disturb the next launch.
    i_Tx_Done = 1'b1; tick(); i_Tx_Done = 1'b0;
    push_byte(8'h3C);
    tick();
    check("after_rst_txdv", 32'(o_Tx_DV), 32'd1);
    check("after_rst_txbyte", 32'(o_Tx_Byte), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
